line_window_buffer: RTL

//  Parametrised K-row line buffer for the pixel pipeline, upstream of the filter/convolution stages.

---
 rtl/line_window_buffer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/line_window_buffer.sv
// K-row sliding line buffer: keeps the last KERNEL_SIZE complete lines in KERNEL_SIZE+1 rotating
// BRAMs and emits one K-tall pixel column per valid input pixel, two cycles after it arrives.
module line_window_buffer #(
  parameter int KERNEL_SIZE = 3,
  parameter int PIXEL_WIDTH = 16,
  parameter int HRES        = 1280,
  parameter int VRES        = 720,
  parameter int EDGE_MODE   = 1
) (
  input  logic                                    clk_in,
  input  logic                                    rst_n_in,
  input  logic [10:0]                             hcount_in,
  input  logic [9:0]                              vcount_in,
  input  logic [PIXEL_WIDTH-1:0]                  pixel_data_in,
  input  logic                                    data_valid_in,
  output logic [KERNEL_SIZE-1:0][PIXEL_WIDTH-1:0] line_buffer_out,
  output logic [10:0]                             hcount_out,
  output logic [9:0]                              vcount_out,
  output logic                                    data_valid_out
);

  // Handshake: data_valid_in qualifies a pixel in the cycle it is high; there is no backpressure,
  // and data_valid_out qualifies the window column in the cycle it is high.

  localparam int R  = (KERNEL_SIZE - 1) / 2;
  localparam int NB = KERNEL_SIZE + 1;
  localparam int SW = $clog2(NB);
  localparam int LW = $clog2(KERNEL_SIZE + 1);
  localparam int AW = (HRES > 1) ? $clog2(HRES) : 1;

  typedef logic [SW-1:0] sel_t;

  logic [AW-1:0] addr;
  assign addr = hcount_in[AW-1:0];

  generate
    if (AW < 11) begin : g_hcount_high
      logic unused_hbits;
      assign unused_hbits = ^hcount_in[10:AW];
    end
  endgenerate

  logic [PIXEL_WIDTH-1:0] mem [NB][HRES];
  logic [PIXEL_WIDTH-1:0] rd1 [NB];
  logic [PIXEL_WIDTH-1:0] rd2 [NB];

  sel_t          wr_sel;
  logic [LW-1:0] lines_written;
  logic          line_end;

  assign line_end = data_valid_in && (hcount_in == 11'(HRES - 1));

  // Read-first BRAM ports: every bank is read at hcount_in each cycle, first register stage.
  always_ff @(posedge clk_in) begin
    if (data_valid_in) mem[wr_sel][addr] <= pixel_data_in;
    for (int b = 0; b < NB; b++) rd1[b] <= mem[b][addr];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_sel        <= sel_t'(KERNEL_SIZE);
      lines_written <= '0;
    end else if (line_end) begin
      wr_sel <= (wr_sel == '0) ? sel_t'(KERNEL_SIZE) : wr_sel - 1'b1;
      if (lines_written != LW'(KERNEL_SIZE)) lines_written <= lines_written + 1'b1;
    end
  end

  // Bank holding window slot 'slot': slot K-1 is the bank written just before wr_sel.
  function automatic sel_t bank_of(input sel_t ws, input int slot);
    int b;
    b = int'(ws) + KERNEL_SIZE - slot;
    if (b >= NB) b = b - NB;
    return sel_t'(b);
  endfunction

  logic [9:0]                      centre;
  logic [KERNEL_SIZE-1:0]          top_c;
  logic [KERNEL_SIZE-1:0]          bot_c;
  logic [KERNEL_SIZE-1:0]          zero0;
  logic [KERNEL_SIZE-1:0][SW-1:0]  bidx0;

  always_comb begin
    top_c = '0;
    bot_c = '0;
    zero0 = '0;
    bidx0 = '0;
    if (vcount_in < 10'(R + 1)) centre = vcount_in + 10'(VRES - R - 1);
    else                        centre = vcount_in - 10'(R + 1);
    for (int j = 0; j < KERNEL_SIZE; j++) begin
      top_c[j] = (j < R) && (centre < 10'(R - j));
      bot_c[j] = (j > R) && (centre > 10'(VRES - 1 + R - j));
      zero0[j] = (EDGE_MODE == 2) && (top_c[j] || bot_c[j]);
      // Replication picks the slot that holds row 0 or row VRES-1 inside the same window.
      if ((EDGE_MODE == 1) && top_c[j])
        bidx0[j] = bank_of(wr_sel, R - int'(centre));
      else if ((EDGE_MODE == 1) && bot_c[j])
        bidx0[j] = bank_of(wr_sel, VRES - 1 + R - int'(centre));
      else
        bidx0[j] = bank_of(wr_sel, j);
    end
  end

  logic                           v1, v2, p1, p2;
  logic [10:0]                    h1, h2;
  logic [9:0]                     c1, c2;
  logic [KERNEL_SIZE-1:0]         zero1, zero2;
  logic [KERNEL_SIZE-1:0][SW-1:0] bidx1, bidx2;

  // Selects, flags and counters travel with the BRAM data so they match its launch cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      p1    <= 1'b0;
      p2    <= 1'b0;
      h1    <= '0;
      h2    <= '0;
      c1    <= '0;
      c2    <= '0;
      zero1 <= '0;
      zero2 <= '0;
      bidx1 <= '0;
      bidx2 <= '0;
      for (int b = 0; b < NB; b++) rd2[b] <= '0;
    end else begin
      v1    <= data_valid_in;
      p1    <= (lines_written == LW'(KERNEL_SIZE));
      h1    <= hcount_in;
      c1    <= centre;
      zero1 <= zero0;
      bidx1 <= bidx0;
      v2    <= v1;
      p2    <= p1;
      h2    <= h1;
      c2    <= c1;
      zero2 <= zero1;
      bidx2 <= bidx1;
      for (int b = 0; b < NB; b++) rd2[b] <= rd1[b];
    end
  end

  always_comb begin
    line_buffer_out = '0;
    for (int j = 0; j < KERNEL_SIZE; j++)
      line_buffer_out[j] = zero2[j] ? '0 : rd2[bidx2[j]];
  end

  assign hcount_out     = h2;
  assign vcount_out     = c2;
  assign data_valid_out = v2 & p2;

endmodule
